zacore_fetch_buffer: RTL and testbench

//  Instruction fetch stage directly upstream of immediate/instruction decode. Generates sequential PCs,

---
 rtl/zacore_fetch_buffer.sv | 143 ++++++++++++++
 tb/tb_zacore_fetch_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zacore_fetch_buffer.sv
// Instruction fetch buffer: sequential PC generation, in-order imem requests,
// and a {pc, inst} FIFO towards decode with redirect flush of in-flight words.

module zacore_fetch_buffer_chk #(
    parameter int CW = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          imem_rsp_valid,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] drop
);
    a_rsp_without_req: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding != {CW{1'b0}}));
    a_drop_bound: assert property (@(posedge clk) disable iff (rst)
        drop <= outstanding);
endmodule

module zacore_fetch_buffer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   rsp_pc_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] drop_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [31:0]   pc_mem_r   [FIFO_DEPTH];
    logic [31:0]   inst_mem_r [FIFO_DEPTH];

    logic          credit_ok_s;
    logic          req_fire_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   redirect_pc_aligned_s;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        if (p == LAST_PTR) begin
            return {AW{1'b0}};
        end else begin
            return p + AW'(1'b1);
        end
    endfunction

    // Handshake decode; credit counts in-flight plus buffered words from registered state only
    always_comb begin
        credit_ok_s           = ({1'b0, outstanding_r} + {1'b0, count_r}) < DEPTH_W;
        redirect_pc_aligned_s = redirect_pc & 32'hFFFF_FFFC;
        imem_req_valid        = 1'b0;
        out_valid             = 1'b0;
        push_s                = 1'b0;
        if (!rst && !redirect_valid) begin
            imem_req_valid = credit_ok_s;
            out_valid      = (count_r != {CW{1'b0}});
            push_s         = imem_rsp_valid && (drop_r == {CW{1'b0}});
        end else begin
            imem_req_valid = 1'b0;
            out_valid      = 1'b0;
            push_s         = 1'b0;
        end
        req_fire_s = imem_req_valid && imem_req_ready;
        pop_s      = out_valid && out_ready;
    end

    assign imem_req_addr = fetch_pc_r;
    assign out_pc        = pc_mem_r[rd_ptr_r];
    assign out_inst      = inst_mem_r[rd_ptr_r];

    // Control state: PCs, occupancy, in-flight and drop counters; redirect outranks everything but reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            count_r       <= {CW{1'b0}};
            outstanding_r <= {CW{1'b0}};
            drop_r        <= {CW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
        end else if (redirect_valid) begin
            fetch_pc_r    <= redirect_pc_aligned_s;
            rsp_pc_r      <= redirect_pc_aligned_s;
            count_r       <= {CW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            // A word landing in the redirect cycle is discarded here, so it is not counted as a drop
            outstanding_r <= outstanding_r - CW'(imem_rsp_valid);
            drop_r        <= outstanding_r - CW'(imem_rsp_valid);
        end else begin
            if (req_fire_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            outstanding_r <= outstanding_r + CW'(req_fire_s) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (drop_r != {CW{1'b0}})) begin
                drop_r <= drop_r - CW'(1'b1);
            end
            if (push_s) begin
                rsp_pc_r <= rsp_pc_r + 32'd4;
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // FIFO payload storage; contents are only meaningful below count_r
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= rsp_pc_r;
            inst_mem_r[wr_ptr_r] <= imem_rsp_data;
        end
    end

    zacore_fetch_buffer_chk #(.CW(CW)) u_chk (
        .clk            (clk),
        .rst            (rst),
        .imem_rsp_valid (imem_rsp_valid),
        .outstanding    (outstanding_r),
        .drop           (drop_r)
    );
endmodule

// File: tb/tb_zacore_fetch_buffer.sv
// Scoreboard bench for zacore_fetch_buffer: an in-order imem model with path
// epochs decides which words survive, and the monitor checks decode output order.

module tb_zacore_fetch_buffer;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    logic        rsp_cur;
    int          checks = 0;
    int          errors = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          ready_pct = 100;
    int          epoch = 0;

    int          kept;
    int          popped;
    int          out_cnt;
    int          fires_path;
    logic [31:0] req_exp;
    logic [31:0] held_addr;
    logic        stalled;
    logic [63:0] exp_q [$];

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } req_t;
    req_t pend [$];

    zacore_fetch_buffer #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // A new path (reset or redirect) defines the whole expected decode stream from its base PC
    task automatic start_path(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            logic [31:0] pc;
            pc = base + 32'(4 * i);
            exp_q.push_back({pc, mem_word(pc)});
        end
        kept       = 0;
        popped     = 0;
        fires_path = 0;
        req_exp    = base;
        stalled    = 1'b0;
    endtask

    // Instruction memory model: in-order, variable latency, random request acceptance
    initial begin
        int   cyc;
        logic rst_seen;
        cyc            = 0;
        rst_seen       = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_req_ready = 1'b1;
        rsp_cur        = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            rst_seen = rst;
            if (rst) begin
                pend.delete();
            end else begin
                if (imem_req_valid && imem_req_ready)
                    pend.push_back('{imem_req_addr, epoch, cyc + $urandom_range(lat_min, lat_max)});
                if (redirect_valid)
                    epoch++;
            end
            @(posedge clk);
            #1;
            if (!rst_seen && pend.size() > 0 && pend[0].due <= cyc + 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend[0].addr);
                rsp_cur        = (pend[0].ep == epoch);
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
                rsp_cur        = 1'b0;
            end
            imem_req_ready = ($urandom_range(1, 100) <= ready_pct);
        end
    end

    // Monitor: compares decode output and request stream against the path model
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            check("rst_out_valid", {31'b0, out_valid}, 32'd0);
            check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            out_cnt = 0;
            start_path(RESET_PC);
        end else if (redirect_valid) begin
            check("redir_out_valid", {31'b0, out_valid}, 32'd0);
            check("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
            if (imem_rsp_valid) out_cnt--;
            start_path(redirect_pc & 32'hFFFF_FFFC);
        end else begin
            check("out_valid", {31'b0, out_valid}, {31'b0, (kept - popped) > 0});
            check("req_valid_credit", {31'b0, imem_req_valid},
                  {31'b0, (out_cnt + kept - popped) < DEPTH});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", out_pc, e[63:32]);
                    check("out_inst", out_inst, e[31:0]);
                end
                popped++;
            end
            if (imem_rsp_valid && rsp_cur) kept++;
            if (imem_rsp_valid) out_cnt--;
            if (imem_req_valid && stalled)
                check("req_addr_held", imem_req_addr, held_addr);
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr_seq", imem_req_addr, req_exp);
                req_exp = req_exp + 32'd4;
                fires_path++;
                out_cnt++;
            end
            stalled   = imem_req_valid && !imem_req_ready;
            held_addr = imem_req_addr;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic wait_out_cnt(input int n, input string name);
        int t;
        t = 0;
        while (out_cnt != n && t < 100) begin
            cycle();
            t++;
        end
        check(name, 32'(out_cnt), 32'(n));
    endtask

    initial begin
        logic found;
        logic prev_redir;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;

        // Streaming with 1-cycle memory and an always-ready decoder
        repeat (3) cycle();
        rst = 1'b0;
        repeat (30) cycle();

        // Decoder stalled: credit caps requests at DEPTH, then drain
        out_ready = 1'b0;
        do_reset();
        repeat (20) cycle();
        #1;
        check("stall_fires", 32'(fires_path), 32'(DEPTH));
        check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (20) cycle();

        // Redirect with three words in flight at latency 3
        lat_min = 3;
        lat_max = 3;
        do_reset();
        wait_out_cnt(3, "three_in_flight");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        cycle();
        redirect_valid = 1'b0;
        repeat (20) cycle();

        // Redirect coinciding with a response and a decode handshake
        lat_min = 2;
        lat_max = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            cycle();
            #1;
            found = imem_rsp_valid && out_valid && out_ready;
        end
        check("coincident_found", {31'b0, found}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        cycle();
        redirect_valid = 1'b0;
        repeat (20) cycle();

        // Random acceptance, latency, backpressure and redirects
        lat_min    = 1;
        lat_max    = 3;
        ready_pct  = 50;
        prev_redir = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = !prev_redir && ($urandom_range(0, 39) == 0);
            redirect_pc    = $urandom;
            prev_redir     = redirect_valid;
            cycle();
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        ready_pct      = 100;
        repeat (10) cycle();

        // Reset mid-stream with two words in flight
        lat_min = 2;
        lat_max = 2;
        wait_out_cnt(2, "two_in_flight");
        do_reset();
        #1;
        check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("post_rst_req_addr", imem_req_addr, RESET_PC);
        repeat (20) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
